// File: rtl/ex_pkg.sv
// Shared types and encodings for the execute stage: ALU/condition codes, SR layout,
// forwarding selects and multiplier FSM states.
package ex_pkg;

  localparam int unsigned ALU_MODE_W = 6;

  typedef enum logic [ALU_MODE_W-1:0] {
    ALU_ADD  = 6'h00,
    ALU_SUB  = 6'h01,
    ALU_AND  = 6'h02,
    ALU_OR   = 6'h03,
    ALU_XOR  = 6'h04,
    ALU_SHL  = 6'h05,
    ALU_SHR  = 6'h06,
    ALU_PASS = 6'h07,
    ALU_MUL  = 6'h08,
    CC_EQ    = 6'h10,
    CC_NE    = 6'h11,
    CC_LT    = 6'h12,
    CC_GE    = 6'h13,
    CC_ZS    = 6'h14,
    CC_CS    = 6'h15
  } alu_mode_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_ALT = 2'd3;

  typedef logic [1:0] mul_state_e;
  localparam mul_state_e MUL_IDLE = 2'd0;
  localparam mul_state_e MUL_RUN  = 2'd1;
  localparam mul_state_e MUL_DONE = 2'd2;

  // Condition codes compute the branch target as op1 + op2 and never touch the multiplier.
  function automatic logic is_cond(input alu_mode_e m);
    return (m == CC_EQ) || (m == CC_NE) || (m == CC_LT) ||
           (m == CC_GE) || (m == CC_ZS) || (m == CC_CS);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: one partial product per RUN cycle, WIDTH cycles per product.
// o_last flags the final RUN cycle, when o_product already carries the complete result.
module seq_multiplier
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_idle,
  output logic                 o_busy,
  output logic                 o_last,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mul_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_step;

  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign o_idle    = (state_q == MUL_IDLE);
  assign o_busy    = (state_q == MUL_RUN);
  assign o_last    = (state_q == MUL_RUN) && (cnt_q == '0);
  assign o_product = acc_step;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      MUL_IDLE: begin
        if (i_start) begin
          state_d  = MUL_RUN;
          cnt_d    = CNT_W'(WIDTH - 1);
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, i_a};
          mplier_d = i_b;
        end
      end
      MUL_RUN: begin
        if (i_abort) begin
          state_d = MUL_IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = MUL_DONE;
        end
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, branch evaluation, status register
// and a sequential multiplier, all registered into the EX/MEM boundary.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MODE_W = 6,
  parameter int unsigned FWD_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_flush,
  input  logic [FWD_W-1:0]  i_oper1_sel,
  input  logic [FWD_W-1:0]  i_oper2_sel,
  input  logic [FWD_W-1:0]  i_wdata_sel,
  input  logic [MODE_W-1:0] i_alu_mode,
  input  logic              i_branch,
  input  logic              i_set_flags,
  input  logic [WIDTH-1:0]  i_reg1,
  input  logic [WIDTH-1:0]  i_reg2,
  input  logic [WIDTH-1:0]  i_imm,
  input  logic [WIDTH-1:0]  i_wb_data,
  input  logic [WIDTH-1:0]  i_mem_fwd,
  output logic              o_busy,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_alu_out,
  output logic [WIDTH-1:0]  o_data_write,
  output logic              o_branch_taken,
  output logic [3:0]        o_flags
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] fwd_pick(input logic [1:0] sel,
                                                input logic [WIDTH-1:0] src0,
                                                input logic [WIDTH-1:0] wb,
                                                input logic [WIDTH-1:0] mem);
    case (sel)
      FWD_WB:           return wb;
      FWD_MEM:          return mem;
      FWD_REG, FWD_ALT: return src0;
      default:          return src0;
    endcase
  endfunction

  logic [WIDTH-1:0]        op1, op2, wdata;
  alu_mode_e               mode;
  logic                    is_mul, can_issue, sc_issue, mul_start, mul_commit;
  logic                    mul_idle, mul_busy, mul_last;
  logic [2*WIDTH-1:0]      mul_prod;
  logic [WIDTH-1:0]        alu_res;
  flags_t                  alu_fl, mul_fl;
  logic                    cond_hit;
  logic [WIDTH:0]          sum_ext, diff_ext, shl_ext, shr_ext;
  logic signed [WIDTH:0]   sadd, ssub;
  logic [SH_W-1:0]         shamt;

  logic                    valid_q, valid_d;
  logic                    taken_q, taken_d;
  logic [WIDTH-1:0]        alu_out_q, alu_out_d;
  logic [WIDTH-1:0]        data_write_q, data_write_d;
  flags_t                  flags_q, flags_d;
  logic [WIDTH-1:0]        mul_wdata_q, mul_wdata_d;
  logic                    mul_setf_q, mul_setf_d;

  assign op1   = fwd_pick(2'(i_oper1_sel), i_reg1, i_wb_data, i_mem_fwd);
  assign op2   = fwd_pick(2'(i_oper2_sel), i_imm,  i_wb_data, i_mem_fwd);
  assign wdata = fwd_pick(2'(i_wdata_sel), i_reg2, i_wb_data, i_mem_fwd);
  assign mode  = alu_mode_e'(ALU_MODE_W'(i_alu_mode));

  assign is_mul     = (mode == ALU_MUL);
  assign can_issue  = i_valid & ~mul_busy & ~i_flush;
  assign sc_issue   = can_issue & ~is_mul;
  assign mul_start  = can_issue & is_mul & mul_idle;
  assign mul_commit = mul_last & ~i_flush;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (mul_start),
    .i_abort   (i_flush),
    .i_a       (op1),
    .i_b       (op2),
    .o_idle    (mul_idle),
    .o_busy    (mul_busy),
    .o_last    (mul_last),
    .o_product (mul_prod)
  );

  // Carry, borrow and shifted-out bits come from one extra bit on each intermediate.
  always_comb begin
    shamt    = op2[SH_W-1:0];
    sum_ext  = {1'b0, op1} + {1'b0, op2};
    diff_ext = {1'b0, op1} - {1'b0, op2};
    shl_ext  = {1'b0, op1} << shamt;
    shr_ext  = {op1, 1'b0} >> shamt;
    sadd     = $signed({op1[WIDTH-1], op1}) + $signed({op2[WIDTH-1], op2});
    ssub     = $signed({op1[WIDTH-1], op1}) - $signed({op2[WIDTH-1], op2});
    alu_res  = op1;
    alu_fl   = '0;
    case (mode)
      ALU_ADD: begin
        alu_res  = sum_ext[WIDTH-1:0];
        alu_fl.c = sum_ext[WIDTH];
        alu_fl.v = sadd[WIDTH] ^ sadd[WIDTH-1];
      end
      ALU_SUB: begin
        alu_res  = diff_ext[WIDTH-1:0];
        alu_fl.c = ~diff_ext[WIDTH];
        alu_fl.v = ssub[WIDTH] ^ ssub[WIDTH-1];
      end
      ALU_AND:  alu_res = op1 & op2;
      ALU_OR:   alu_res = op1 | op2;
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_PASS: alu_res = op2;
      ALU_SHL: begin
        alu_res  = shl_ext[WIDTH-1:0];
        alu_fl.c = shl_ext[WIDTH];
      end
      ALU_SHR: begin
        alu_res  = shr_ext[WIDTH:1];
        alu_fl.c = shr_ext[0];
      end
      default: begin
        if (is_cond(mode)) begin
          alu_res  = sum_ext[WIDTH-1:0];
          alu_fl.c = sum_ext[WIDTH];
          alu_fl.v = sadd[WIDTH] ^ sadd[WIDTH-1];
        end
      end
    endcase
    alu_fl.n = alu_res[WIDTH-1];
    alu_fl.z = (alu_res == '0);
  end

  // Ordered conditions read the SR as it stands before this instruction commits.
  always_comb begin
    cond_hit = 1'b0;
    case (mode)
      CC_EQ:   cond_hit = (op1 == wdata);
      CC_NE:   cond_hit = (op1 != wdata);
      CC_LT:   cond_hit = flags_q.n ^ flags_q.v;
      CC_GE:   cond_hit = ~(flags_q.n ^ flags_q.v);
      CC_ZS:   cond_hit = flags_q.z;
      CC_CS:   cond_hit = flags_q.c;
      default: cond_hit = 1'b0;
    endcase
  end

  always_comb begin
    mul_fl.n = mul_prod[WIDTH-1];
    mul_fl.z = (mul_prod[WIDTH-1:0] == '0);
    mul_fl.c = |mul_prod[2*WIDTH-1:WIDTH];
    mul_fl.v = |mul_prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    valid_d      = 1'b0;
    taken_d      = 1'b0;
    alu_out_d    = alu_out_q;
    data_write_d = data_write_q;
    flags_d      = flags_q;
    mul_wdata_d  = mul_wdata_q;
    mul_setf_d   = mul_setf_q;
    if (sc_issue) begin
      valid_d      = 1'b1;
      alu_out_d    = alu_res;
      data_write_d = wdata;
      taken_d      = i_branch & cond_hit;
      if (i_set_flags) flags_d = alu_fl;
    end
    if (mul_start) begin
      mul_wdata_d = wdata;
      mul_setf_d  = i_set_flags;
    end
    if (mul_commit) begin
      valid_d      = 1'b1;
      alu_out_d    = mul_prod[WIDTH-1:0];
      data_write_d = mul_wdata_q;
      if (mul_setf_q) flags_d = mul_fl;
    end
  end

  // EX/MEM boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      alu_out_q    <= '0;
      data_write_q <= '0;
      flags_q      <= '0;
      mul_wdata_q  <= '0;
      mul_setf_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      alu_out_q    <= alu_out_d;
      data_write_q <= data_write_d;
      flags_q      <= flags_d;
      mul_wdata_q  <= mul_wdata_d;
      mul_setf_q   <= mul_setf_d;
    end
  end

  assign o_busy         = mul_busy;
  assign o_valid        = valid_q;
  assign o_alu_out      = alu_out_q;
  assign o_data_write   = data_write_q;
  assign o_branch_taken = taken_q;
  assign o_flags        = flags_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: a vector table of single-cycle ops plus hand-written
// multiply, flush and reset sequences.
module tb_ex_stage_mc;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_flush, i_branch, i_set_flags;
  logic [1:0]  i_oper1_sel, i_oper2_sel, i_wdata_sel;
  logic [5:0]  i_alu_mode;
  logic [15:0] i_reg1, i_reg2, i_imm, i_wb_data, i_mem_fwd;
  logic        o_busy, o_valid, o_branch_taken;
  logic [15:0] o_alu_out, o_data_write;
  logic [3:0]  o_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage_mc #(.WIDTH(16), .MODE_W(6), .FWD_W(2)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_oper1_sel(i_oper1_sel), .i_oper2_sel(i_oper2_sel), .i_wdata_sel(i_wdata_sel),
    .i_alu_mode(i_alu_mode), .i_branch(i_branch), .i_set_flags(i_set_flags),
    .i_reg1(i_reg1), .i_reg2(i_reg2), .i_imm(i_imm),
    .i_wb_data(i_wb_data), .i_mem_fwd(i_mem_fwd),
    .o_busy(o_busy), .o_valid(o_valid), .o_alu_out(o_alu_out),
    .o_data_write(o_data_write), .o_branch_taken(o_branch_taken), .o_flags(o_flags)
  );

  typedef struct {
    logic [1:0]  s1, s2, sw;
    logic [5:0]  mode;
    logic        br, sf;
    logic [15:0] r1, r2, imm, wb, mem;
    logic [15:0] e_out, e_dw;
    logic        e_tk;
    logic [3:0]  e_fl;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input logic [1:0] s1, s2, sw, input logic [5:0] mode,
                              input logic br, sf, input logic [15:0] r1, r2, imm, wb, mem,
                              input logic [15:0] e_out, e_dw, input logic e_tk,
                              input logic [3:0] e_fl);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.sw = sw; v.mode = mode; v.br = br; v.sf = sf;
    v.r1 = r1; v.r2 = r2; v.imm = imm; v.wb = wb; v.mem = mem;
    v.e_out = e_out; v.e_dw = e_dw; v.e_tk = e_tk; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_flush = 0; i_branch = 0; i_set_flags = 0;
    i_oper1_sel = 0; i_oper2_sel = 0; i_wdata_sel = 0; i_alu_mode = ALU_ADD;
    i_reg1 = 0; i_reg2 = 0; i_imm = 0; i_wb_data = 0; i_mem_fwd = 0;
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    @(negedge clk);
    i_valid = 1; i_flush = 0;
    i_oper1_sel = v.s1; i_oper2_sel = v.s2; i_wdata_sel = v.sw;
    i_alu_mode = v.mode; i_branch = v.br; i_set_flags = v.sf;
    i_reg1 = v.r1; i_reg2 = v.r2; i_imm = v.imm; i_wb_data = v.wb; i_mem_fwd = v.mem;
    @(posedge clk); #1;
    chk({nm, "_valid"}, o_valid, 1);
    chk({nm, "_out"}, o_alu_out, v.e_out);
    chk({nm, "_dw"}, o_data_write, v.e_dw);
    chk({nm, "_taken"}, o_branch_taken, v.e_tk);
    chk({nm, "_flags"}, o_flags, v.e_fl);
  endtask

  task automatic issue_mul(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    i_valid = 1; i_flush = 0; i_alu_mode = ALU_MUL; i_branch = 0; i_set_flags = 1;
    i_oper1_sel = 0; i_oper2_sel = 0; i_wdata_sel = 0;
    i_reg1 = a; i_imm = b; i_reg2 = 16'h5A5A;
    @(posedge clk); #1;
    chk("mul_busy_after_issue", o_busy, 1);
    chk("mul_no_valid_after_issue", o_valid, 0);
    i_reg1 = 16'hFFFF; i_imm = 16'hFFFF; i_reg2 = 16'h0000;
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e_out, input logic [3:0] e_fl, input string nm);
    int n;
    int early;
    issue_mul(a, b);
    n = 0;
    early = 0;
    while (o_busy === 1'b1 && n < 40) begin
      n++;
      if (o_valid !== 1'b0) early++;
      @(posedge clk); #1;
    end
    chk({nm, "_busy_cycles"}, n, 16);
    chk({nm, "_early_valid"}, early, 0);
    chk({nm, "_valid"}, o_valid, 1);
    chk({nm, "_out"}, o_alu_out, e_out);
    chk({nm, "_dw"}, o_data_write, 16'h5A5A);
    chk({nm, "_flags"}, o_flags, e_fl);
    chk({nm, "_taken"}, o_branch_taken, 0);
    i_valid = 0;
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, o_valid, 0);
    chk({nm, "_busy_idle"}, o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_out", o_alu_out, 0);
    chk("rst_dw", o_data_write, 0);
    chk("rst_taken", o_branch_taken, 0);
    chk("rst_flags", o_flags, 0);
    @(negedge clk);
    rst = 0;

    vt[0]  = mk(0, 0, 0, ALU_ADD,  0, 1, 16'h7FFF, 16'h00AA, 16'h0001, 16'h0000, 16'h0000, 16'h8000, 16'h00AA, 0, 4'b1001);
    vt[1]  = mk(2, 0, 0, ALU_SUB,  0, 1, 16'h0000, 16'h00AA, 16'h0010, 16'h0000, 16'h0010, 16'h0000, 16'h00AA, 0, 4'b0110);
    vt[2]  = mk(3, 0, 0, ALU_SUB,  0, 1, 16'h0020, 16'h00AA, 16'h0010, 16'h0000, 16'h0010, 16'h0010, 16'h00AA, 0, 4'b0010);
    vt[3]  = mk(0, 1, 0, ALU_AND,  0, 1, 16'hF0F0, 16'h00AA, 16'h0000, 16'h0FF0, 16'h0000, 16'h00F0, 16'h00AA, 0, 4'b0000);
    vt[4]  = mk(0, 2, 2, ALU_OR,   0, 0, 16'hF000, 16'h00AA, 16'h0000, 16'h0000, 16'h000F, 16'hF00F, 16'h000F, 0, 4'b0000);
    vt[5]  = mk(0, 0, 0, ALU_XOR,  0, 1, 16'hFFFF, 16'h00AA, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h00AA, 0, 4'b0100);
    vt[6]  = mk(0, 0, 0, ALU_SHL,  0, 1, 16'h8001, 16'h00AA, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h00AA, 0, 4'b0010);
    vt[7]  = mk(0, 0, 0, ALU_SHR,  0, 1, 16'h0003, 16'h00AA, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 16'h00AA, 0, 4'b0110);
    vt[8]  = mk(0, 0, 0, ALU_SHL,  0, 1, 16'h8000, 16'h00AA, 16'h0010, 16'h0000, 16'h0000, 16'h8000, 16'h00AA, 0, 4'b1000);
    vt[9]  = mk(0, 3, 3, ALU_PASS, 0, 1, 16'h0000, 16'h00BB, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h00BB, 0, 4'b0000);
    vt[10] = mk(0, 0, 1, CC_EQ,    1, 0, 16'h1234, 16'h9999, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 16'h1234, 1, 4'b0000);
    vt[11] = mk(0, 0, 1, CC_EQ,    0, 0, 16'h1234, 16'h9999, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 16'h1234, 0, 4'b0000);
    vt[12] = mk(0, 0, 0, ALU_SUB,  0, 1, 16'h0002, 16'h00AA, 16'h0005, 16'h0000, 16'h0000, 16'hFFFD, 16'h00AA, 0, 4'b1000);
    vt[13] = mk(0, 0, 0, CC_LT,    1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 4'b1000);
    vt[14] = mk(0, 0, 0, CC_GE,    1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b1000);
    vt[15] = mk(0, 0, 0, CC_NE,    1, 0, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 1, 4'b1000);

    for (int i = 0; i < 16; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

    i_valid = 0; i_branch = 0; i_set_flags = 0;
    @(posedge clk); #1;
    chk("idle_valid", o_valid, 0);
    chk("idle_taken", o_branch_taken, 0);
    chk("idle_out_hold", o_alu_out, 16'h0001);
    chk("idle_dw_hold", o_data_write, 16'h0002);

    run_mul(16'h0100, 16'h0100, 16'h0000, 4'b0111, "mul_big");
    run_mul(16'h0003, 16'h0005, 16'h000F, 4'b0000, "mul_small");

    apply_vec(mk(0, 0, 0, ALU_ADD, 0, 1, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 0, 4'b0111), "add_ovf");

    // Flush during RUN cycle 5
    issue_mul(16'h0003, 16'h0005);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("flush_pre_busy", o_busy, 1);
    i_flush = 1; i_valid = 0;
    @(posedge clk); #1;
    chk("flush_busy_drop", o_busy, 0);
    chk("flush_no_valid", o_valid, 0);
    i_flush = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (o_valid === 1'b1) pulses++;
    end
    chk("flush_pulses", pulses, 0);
    chk("flush_sr_kept", o_flags, 4'b0111);
    chk("flush_out_kept", o_alu_out, 16'h0000);

    // Flush on the issue cycle
    @(negedge clk);
    i_valid = 1; i_flush = 1; i_alu_mode = ALU_ADD; i_set_flags = 1;
    i_reg1 = 16'h0001; i_imm = 16'h0001;
    @(posedge clk); #1;
    chk("flush_issue_valid", o_valid, 0);
    chk("flush_issue_out", o_alu_out, 16'h0000);
    chk("flush_issue_flags", o_flags, 4'b0111);
    i_flush = 0; i_valid = 0;

    apply_vec(mk(0, 0, 0, ALU_SUB, 0, 1, 16'h0002, 16'h5A5A, 16'h0005, 16'h0000, 16'h0000,
                 16'hFFFD, 16'h5A5A, 0, 4'b1000), "sub_pre_rst");

    // Reset in the middle of RUN
    issue_mul(16'h0003, 16'h0005);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1; i_valid = 0;
    @(posedge clk); #1;
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_valid", o_valid, 0);
    chk("rstmid_out", o_alu_out, 0);
    chk("rstmid_dw", o_data_write, 0);
    chk("rstmid_taken", o_branch_taken, 0);
    chk("rstmid_flags", o_flags, 0);
    rst = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (o_valid === 1'b1 || o_busy === 1'b1) pulses++;
    end
    chk("rstmid_quiet", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
